// File: rtl/rrotate32_pipe_pkg.sv
// Shared definitions for the pipelined right rotator/shifter: widths and the
// operation mode encoding.
package rrotate32_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // RSV behaves as rotate-right; it only exists so every encoding has a name.
  typedef enum logic [1:0] {
    ROR = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    RSV = 2'b11
  } mode_e;

endpackage

// File: rtl/rrotate32_pipe_stage.sv
// One pipeline stage of the right rotator: conditionally shifts right by SH
// with mode-dependent fill, and registers the result behind a valid/ready pair.
module rrotate_stage
  import rrotate32_pipe_pkg::*;
#(
  parameter int SH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SHAMT_W-1:0] in_shr,
  input  logic [1:0]        in_mode,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SHAMT_W-1:0] out_shr,
  output logic [1:0]        out_mode,
  output logic              out_sign
);

  localparam int BIT = $clog2(SH);

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] shr_q, shr_d;
  logic [1:0]         mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [SH-1:0]      fill;
  logic [DATA_W-1:0]  shifted;

  // Bubble-collapsing: an empty stage accepts even while downstream is stalled.
  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fill = in_data[SH-1:0];
    case (mode_e'(in_mode))
      LSR:     fill = '0;
      ASR:     fill = {SH{in_sign}};
      default: fill = in_data[SH-1:0];
    endcase
    shifted = in_shr[BIT] ? {fill, in_data[DATA_W-1:SH]} : in_data;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shr_d   = shr_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = shifted;
        shr_d  = in_shr;
        mode_d = in_mode;
        sign_d = in_sign;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    if (rst) begin
      // NOTE: payload is cleared too, so OUT reads zero after reset, not stale data.
      valid_q <= 1'b0;
      data_q  <= '0;
      shr_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shr_q   <= shr_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shr   = shr_q;
  assign out_mode  = mode_q;
  assign out_sign  = sign_q;

endmodule

// File: rtl/rrotate32_pipe.sv
// Five-stage pipelined 32-bit right rotator/shifter; stage k handles shift
// amount bit k. Valid/ready handshake on both the input and output sides.
module rrotate32_pipe
  import rrotate32_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [4:0]  shr,
  input  logic [1:0]  mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] OUT
);

  // Index 0 is the input side, index 5 the output side of the chain.
  logic               vld  [0:5];
  logic               rdy  [0:5];
  logic [DATA_W-1:0]  dat  [0:5];
  logic [SHAMT_W-1:0] amt  [0:5];
  logic [1:0]         md   [0:5];
  logic               sgn  [0:5];

  assign vld[0]    = in_valid;
  assign dat[0]    = A;
  assign amt[0]    = shr;
  assign md[0]     = mode;
  assign sgn[0]    = A[31];
  assign rdy[5]    = out_ready;
  assign in_ready  = rdy[0];
  assign out_valid = vld[5];
  assign OUT       = dat[5];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    rrotate_stage #(.SH(1 << k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (dat[k]),
      .in_shr    (amt[k]),
      .in_mode   (md[k]),
      .in_sign   (sgn[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (dat[k+1]),
      .out_shr   (amt[k+1]),
      .out_mode  (md[k+1]),
      .out_sign  (sgn[k+1])
    );
  end

endmodule

// File: tb/tb_rrotate32_pipe.sv
// Self-checking bench for rrotate32_pipe: directed vectors, back-pressure,
// mid-flight reset and randomized traffic against a scoreboard.
module tb_rrotate32_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [4:0]  shr;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] OUT;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        stalled = 1'b0;
  logic [31:0] held    = '0;
  logic        saw_full = 1'b0;
  logic        rand_done;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:9];

  rrotate32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .shr       (shr),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT)
  );

  always #5 clk = ~clk;

  // Reference: rotate via a doubled word, shifts via native operators.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [4:0] s,
                                            input logic [1:0] m);
    logic [63:0] dbl;
    dbl = {a, a} >> s;
    case (m)
      2'b01:   return a >> s;
      2'b10:   return $unsigned($signed(a) >>> s);
      default: return dbl[31:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: inputs are stable from posedge+1 until the next posedge, so the
  // negedge sees exactly the transfers that the coming edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_out", OUT, held);
      end
      if (!in_ready) begin
        saw_full = 1'b1;
        check("in_ready_low_cause", {30'd0, out_valid, out_ready}, 32'd2);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(A, shr, mode));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", OUT);
        end else begin
          check("scoreboard", OUT, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = OUT;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge,
  // with in_valid still high so a following send can be back-to-back.
  task automatic send(input logic [31:0] a, input logic [4:0] s, input logic [1:0] m);
    bit ok = 1'b0;
    in_valid = 1'b1;
    A = a; shr = s; mode = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Latency counts clock edges, including the accepting edge, until OUT is valid.
  task automatic directed(input vec_t v, input string name);
    int n = 1;
    send(v.a, v.s, v.m);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); n++; #1;
      if (out_valid) break;
    end
    check({name, "_latency"}, n, 5);
    check(name, OUT, v.exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; shr = '0; mode = '0;
    rand_done = 1'b0;
    vecs[0] = '{32'h80000001, 5'd1,  2'b00, 32'hC0000000};
    vecs[1] = '{32'h80000000, 5'd31, 2'b01, 32'h00000001};
    vecs[2] = '{32'hFFFFFFFF, 5'd16, 2'b01, 32'h0000FFFF};
    vecs[3] = '{32'h80000000, 5'd4,  2'b10, 32'hF8000000};
    vecs[4] = '{32'h7FFFFFFF, 5'd4,  2'b10, 32'h07FFFFFF};
    vecs[5] = '{32'h12345678, 5'd0,  2'b00, 32'h12345678};
    vecs[6] = '{32'h12345678, 5'd0,  2'b01, 32'h12345678};
    vecs[7] = '{32'h12345678, 5'd0,  2'b10, 32'h12345678};
    vecs[8] = '{32'h12345678, 5'd0,  2'b11, 32'h12345678};
    vecs[9] = '{32'h12345678, 5'd8,  2'b11, 32'h78123456};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", OUT, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) directed(vecs[i], $sformatf("directed%0d", i));
    drain();

    // Back-pressure: 8 back-to-back inputs with out_ready low in cycles 3..9.
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'hA5000000 | i, 5'(i * 3), 2'(i));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 3 && c <= 9);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_in_ready_dropped", {31'd0, saw_full}, 32'd1);

    // Reset with three results in flight: none may emerge afterwards.
    send(32'hDEADBEEF, 5'd3, 2'b00);
    send(32'h01234567, 5'd7, 2'b01);
    send(32'h89ABCDEF, 5'd9, 2'b10);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_out", OUT, 32'h0);
    for (int i = 0; i < 10; i++) begin
      check("midreset_no_output", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Randomized traffic with random idle cycles and random back-pressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          else send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
